// File: rtl/mem_access_unit.sv
// mem_access_unit: single-port byte-addressable data memory behind a
// valid/ready request and a one-cycle response strobe.
// Optional feature macro: MEM_MISALIGNED_SPLIT_EN (split misaligned accesses).
module mem_access_unit #(
    parameter int SIZE        = 3,
    parameter int WAIT_STATES = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            wr_rd,
    input  logic [SIZE+2:0] addr,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [31:0]     data_in,
    output logic            resp_valid,
    output logic [31:0]     data_out,
    output logic            exception_out
);
    localparam int AW    = SIZE + 3;
    localparam int WW    = SIZE + 1;
    localparam int WORDS = 1 << WW;
    localparam logic [3:0] WS_LAST =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
`ifdef MEM_MISALIGNED_SPLIT_EN
        ,
        ACCESS_LO,
        ACCESS_HI
`endif
    } state_t;

    state_t          r_state;
    state_t          w_next;
    state_t          w_go_in;
    state_t          w_go_lat;
    logic [3:0]      r_wcnt;
    logic            r_wr;
    logic            r_sgn;
    logic [1:0]      r_size;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_data;
    logic [31:0]     r_mem [WORDS];

    logic            w_accept;
    logic            w_misal;
    logic            w_fault;
    logic [4:0]      w_sh;
    logic [WW-1:0]   w_widx;
    logic [WW-1:0]   w_maddr;
    logic [3:0]      w_wbe;
    logic [31:0]     w_wword;
    logic [31:0]     w_rword;
    logic [31:0]     w_load;
    logic            w_wen;
    logic            w_fin;

    // Byte-enable pattern of an access at lane 0.
    function automatic logic [3:0] f_be(input logic [1:0] s);
        unique case (s)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Zero- or sign-extend an LSB-aligned load value.
    function automatic logic [31:0] f_ext(
        input logic [31:0] v,
        input logic [1:0]  s,
        input logic        sg
    );
        unique case (s)
            2'b00:   return {{24{sg & v[7]}}, v[7:0]};
            2'b01:   return {{16{sg & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    assign w_accept   = req_valid & req_ready;
    assign req_ready  = (r_state == IDLE) & ~RST;
    assign resp_valid = (r_state == RESP);
    assign w_misal    = ((size == 2'b01) & addr[0])
                      | ((size == 2'b10) & (addr[1:0] != 2'b00));
    assign w_sh       = {r_addr[1:0], 3'b000};
    assign w_widx     = r_addr[AW-1:2];
    assign w_rword    = r_mem[w_maddr];

`ifdef MEM_MISALIGNED_SPLIT_EN
    logic            r_split;
    logic [31:0]     r_lo;
    logic            w_cross;
    logic            w_last;
    logic            w_split_in;
    logic            w_hi_ph;
    logic [7:0]      w_be8;
    logic [63:0]     w_wd64;
    logic [63:0]     w_rd64;

    // Only a crossing access into the non-existent word past the end faults.
    assign w_cross    = ((size == 2'b01) & (addr[1:0] == 2'b11))
                      | ((size == 2'b10) & (addr[1:0] != 2'b00));
    assign w_last     = (addr[AW-1:2] == {WW{1'b1}});
    assign w_fault    = (size == 2'b11) | (w_cross & w_last);
    assign w_split_in = w_misal & ~w_fault;
    assign w_go_in    = w_split_in ? ACCESS_LO : ACCESS;
    assign w_go_lat   = r_split ? ACCESS_LO : ACCESS;

    assign w_hi_ph    = (r_state == ACCESS_HI);
    assign w_be8      = {4'b0000, f_be(r_size)} << r_addr[1:0];
    assign w_wd64     = {32'd0, r_data} << w_sh;
    assign w_maddr    = w_hi_ph ? w_widx + WW'(1) : w_widx;
    assign w_wbe      = w_hi_ph ? w_be8[7:4] : w_be8[3:0];
    assign w_wword    = w_hi_ph ? w_wd64[63:32] : w_wd64[31:0];
    assign w_rd64     = w_hi_ph ? {w_rword, r_lo} : {32'd0, w_rword};
    assign w_load     = f_ext(32'(w_rd64 >> w_sh), r_size, r_sgn);
    assign w_wen      = r_wr & ((r_state == ACCESS)
                      | (r_state == ACCESS_LO) | w_hi_ph);
    assign w_fin      = (r_state == ACCESS) | w_hi_ph;

    // Keep the low word of a split load until the high word arrives.
    always_ff @(posedge CLK) begin
        if (r_state == ACCESS_LO) r_lo <= w_rword;
    end

    // Remember whether the accepted request needs two array cycles.
    always_ff @(posedge CLK) begin
        if (w_accept) r_split <= w_split_in;
    end
`else
    assign w_fault    = (size == 2'b11) | w_misal;
    assign w_go_in    = ACCESS;
    assign w_go_lat   = ACCESS;
    assign w_maddr    = w_widx;
    assign w_wbe      = f_be(r_size) << r_addr[1:0];
    assign w_wword    = r_data << w_sh;
    assign w_load     = f_ext(w_rword >> w_sh, r_size, r_sgn);
    assign w_wen      = r_wr & (r_state == ACCESS);
    assign w_fin      = (r_state == ACCESS);
`endif

    // Next-state logic of the request sequencer.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_fault)              w_next = RESP;
                    else if (WAIT_STATES > 0) w_next = WAIT;
                    else                      w_next = w_go_in;
                end
            end
            WAIT:      if (r_wcnt == WS_LAST) w_next = w_go_lat;
            ACCESS:    w_next = RESP;
`ifdef MEM_MISALIGNED_SPLIT_EN
            ACCESS_LO: w_next = ACCESS_HI;
            ACCESS_HI: w_next = RESP;
`endif
            RESP:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // State, wait counter and held response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_wcnt        <= 4'd0;
            data_out      <= 32'd0;
            exception_out <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == WAIT) r_wcnt <= r_wcnt + 4'd1;
            if (w_accept) begin
                r_wcnt <= 4'd0;
                if (w_fault) begin
                    data_out      <= 32'd0;
                    exception_out <= 1'b1;
                end
            end
            if (w_fin) begin
                data_out      <= r_wr ? 32'd0 : w_load;
                exception_out <= 1'b0;
            end
        end
    end

    // Capture the request so later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_wr   <= wr_rd;
            r_sgn  <= sign_ext;
            r_size <= size;
            r_addr <= addr;
            r_data <= data_in;
        end
    end

    // Byte-lane array write; a reset on the access edge drops it.
    always_ff @(posedge CLK) begin
        if (w_wen && !RST) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wbe[b]) r_mem[w_maddr][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit, two instances
// (no wait states and three wait states) against a byte-array model.
module tb_mem_access_unit;
    localparam int SIZE = 3;
    localparam int AW   = SIZE + 3;
    localparam int NB   = 1 << AW;
    localparam int P    = 10;
    localparam int WS0  = 0;
    localparam int WS1  = 3;

    typedef struct {
        logic [31:0] d;
        logic        e;
        longint      t;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst  [2];
    logic          rv   [2];
    logic          rdy  [2];
    logic          wr   [2];
    logic [AW-1:0] ad   [2];
    logic [1:0]    sz   [2];
    logic          se   [2];
    logic [31:0]   di   [2];
    logic          resp [2];
    logic [31:0]   dout [2];
    logic          exc  [2];

    exp_t          sbq [2][$];
    logic [7:0]    mm [2][NB];
    longint        last_acc [2];
    int            last_lat [2];
    bit            held [2];
    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          me;

    always #(P/2) clk = ~clk;

    mem_access_unit #(.SIZE(SIZE), .WAIT_STATES(WS0)) u0 (
        .CLK(clk), .RST(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]),
        .wr_rd(wr[0]), .addr(ad[0]), .size(sz[0]), .sign_ext(se[0]),
        .data_in(di[0]), .resp_valid(resp[0]), .data_out(dout[0]),
        .exception_out(exc[0])
    );

    mem_access_unit #(.SIZE(SIZE), .WAIT_STATES(WS1)) u1 (
        .CLK(clk), .RST(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]),
        .wr_rd(wr[1]), .addr(ad[1]), .size(sz[1]), .sign_ext(se[1]),
        .data_in(di[1]), .resp_valid(resp[1]), .data_out(dout[1]),
        .exception_out(exc[1])
    );

    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    function automatic void chk(
        input string nm, input logic [31:0] act, input logic [31:0] exp
    );
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endfunction

    // Issue one request at a negedge; on acceptance the model computes
    // the response and its due time and pushes it to the scoreboard.
    task automatic issue(
        input int d, input bit w, input int a, input int s,
        input bit sg, input logic [31:0] data, input bit drop
    );
        exp_t        e;
        int          n;
        int          lat;
        bit          f;
        bit          mis;
        bit          sp;
        bit          ok;
        longint      ta;
        logic [31:0] v;
        logic [31:0] m;
        wr[d] = w;
        ad[d] = AW'(a);
        sz[d] = 2'(s);
        se[d] = sg;
        di[d] = data;
        rv[d] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rdy[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: ready never 1, want 1", d);
            rv[d]   = 1'b0;
            held[d] = 1'b0;
            return;
        end
        @(posedge clk);
        ta = $time;
        if (held[d]) begin
            n_tests++;
            if (ta - last_acc[d] != longint'((last_lat[d] + 1) * P)) begin
                n_fail++;
                $display("FAIL throughput dut%0d: gap %0d, want %0d",
                         d, ta - last_acc[d], (last_lat[d] + 1) * P);
            end
        end
        n   = (s == 0) ? 1 : (s == 1) ? 2 : 4;
        mis = ((s == 1) && (a % 2 != 0)) || ((s == 2) && (a % 4 != 0));
`ifdef MEM_MISALIGNED_SPLIT_EN
        f  = (s == 3) || (((a % 4) + n > 4) && (a / 4 == NB / 4 - 1));
        sp = mis && !f;
`else
        f  = (s == 3) || mis;
        sp = 1'b0;
`endif
        lat = f ? 1 : 2 + ws_of(d) + (sp ? 1 : 0);
        e.d = 32'd0;
        e.e = f;
        if (!f && !drop) begin
            if (w) begin
                for (int i = 0; i < n; i++) mm[d][a+i] = data[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mm[d][a+i];
                if (sg && n < 4 && v[8*n-1]) begin
                    m = (32'h1 << (8 * n)) - 32'h1;
                    v = v | ~m;
                end
                e.d = v;
            end
        end
        e.t = ta + longint'((lat - 1) * P + P / 2);
        if (!drop) sbq[d].push_back(e);
        last_acc[d] = ta;
        last_lat[d] = lat;
        held[d]     = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int d);
        rv[d]   = 1'b0;
        held[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_dut(input int d);
        for (int i = 0; i < NB / 4; i++) issue(d, 1, 4 * i, 2, 0, $urandom, 0);
        idle(d);
        issue(d, 1, 8, 2, 0, 32'hDEADBEEF, 0);
        issue(d, 0, 8, 2, 0, 32'd0, 0);
        issue(d, 1, 10, 0, 0, 32'h00000080, 0);
        issue(d, 0, 10, 0, 1, 32'd0, 0);
        issue(d, 0, 10, 0, 0, 32'd0, 0);
        issue(d, 0, 8, 2, 0, 32'd0, 0);
        issue(d, 0, 3, 1, 0, 32'd0, 0);
        issue(d, 1, 0, 3, 0, 32'hFFFFFFFF, 0);
        issue(d, 1, 2, 2, 0, 32'hFFFFFFFF, 0);
        issue(d, 0, 0, 2, 0, 32'd0, 0);
        issue(d, 0, 4, 2, 1, 32'd0, 0);
        issue(d, 0, NB - 1, 1, 1, 32'd0, 0);
        issue(d, 0, NB - 2, 1, 1, 32'd0, 0);
        idle(d);
        repeat (120) begin
            issue(d, 1'($urandom), int'($urandom % NB), int'($urandom % 4),
                  1'($urandom), $urandom, 0);
            if ($urandom % 4 == 0) begin
                idle(d);
                repeat ($urandom % 3) @(negedge clk);
            end
        end
        idle(d);
    endtask

    // Monitor: every response is matched against the scoreboard head.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d]) begin
                if (resp[d] === 1'b1) begin
                    n_tests++;
                    if (sbq[d].size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_resp dut%0d: data %h exc %b",
                                 d, dout[d], exc[d]);
                    end else begin
                        me = sbq[d].pop_front();
                        if (dout[d] !== me.d || exc[d] !== me.e
                            || $time != me.t) begin
                            n_fail++;
                            $display("FAIL resp dut%0d: got d=%h e=%b t=%0d, want d=%h e=%b t=%0d",
                                     d, dout[d], exc[d], $time,
                                     me.d, me.e, me.t);
                        end
                    end
                end else if (sbq[d].size() > 0 && $time > sbq[d][0].t) begin
                    n_tests++;
                    n_fail++;
                    me = sbq[d].pop_front();
                    $display("FAIL resp_timeout dut%0d: none at t=%0d, want d=%h e=%b",
                             d, me.t, me.d, me.e);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]  = 1'b1;
            rv[d]   = 1'b0;
            wr[d]   = 1'b0;
            ad[d]   = '0;
            sz[d]   = 2'b00;
            se[d]   = 1'b0;
            di[d]   = 32'd0;
            held[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", 32'(rdy[d]), 32'd0);
            chk("reset_resp", 32'(resp[d]), 32'd0);
            chk("reset_data", dout[d], 32'd0);
            chk("reset_exc", 32'(exc[d]), 32'd0);
        end
        for (int d = 0; d < 2; d++) rst[d] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) chk("ready_after_reset", 32'(rdy[d]), 32'd1);
        @(negedge clk);

        run_dut(0);
        run_dut(1);

        issue(1, 1, 16, 2, 0, 32'h12345678, 1);
        rv[1]   = 1'b0;
        held[1] = 1'b0;
        rst[1]  = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        chk("ready_after_mid_reset", 32'(rdy[1]), 32'd1);
        @(negedge clk);
        repeat (6) @(negedge clk);
        issue(1, 0, 16, 2, 0, 32'd0, 0);
        issue(1, 0, 16, 0, 1, 32'd0, 0);
        idle(1);

        for (int i = 0; i < 50; i++) begin
            if (sbq[0].size() == 0 && sbq[1].size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
